// File: rtl/rd_req_arbiter_if.sv
// Engine-side and CCI-P channel-0 read signals shared by the read-request arbiter and its neighbours.
// Latency: req_ready is combinational; tx-request and response outputs are registered one cycle in the arbiter.
// Backpressure: engines hold a request until req_ready; spl_tx_rd_almostfull blocks all grants.
interface rd_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 42
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*12-1:0]     req_tag;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      spl_tx_rd_almostfull;
    logic                      afu_tx_rd_valid;
    logic [ADDR_W-1:0]         afu_tx_rd_addr;
    logic [15:0]               afu_tx_rd_mdata;
    logic                      spl_rx_rd_valid;
    logic [15:0]               spl_rx_rd_mdata;
    logic [511:0]              spl_rx_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [11:0]               rsp_tag;
    logic [511:0]              rsp_data;
    logic                      err_sticky;
    logic [NUM_REQ*32-1:0]     stat_grant_cnt;
    logic [31:0]               stat_stall_cnt;

    modport master (
        output req_valid, req_addr, req_tag, spl_tx_rd_almostfull,
        output spl_rx_rd_valid, spl_rx_rd_mdata, spl_rx_data,
        input  req_ready, afu_tx_rd_valid, afu_tx_rd_addr, afu_tx_rd_mdata,
        input  rsp_valid, rsp_tag, rsp_data, err_sticky, stat_grant_cnt, stat_stall_cnt
    );

    modport slave (
        input  req_valid, req_addr, req_tag, spl_tx_rd_almostfull,
        input  spl_rx_rd_valid, spl_rx_rd_mdata, spl_rx_data,
        output req_ready, afu_tx_rd_valid, afu_tx_rd_addr, afu_tx_rd_mdata,
        output rsp_valid, rsp_tag, rsp_data, err_sticky, stat_grant_cnt, stat_stall_cnt
    );
endinterface

// File: rtl/rd_req_arbiter.sv
// Round-robin arbiter for the CCI-P c0 read-request port with per-engine credits; steers responses by mdata[15:12].
// Latency: grant -> afu_tx_rd_valid 1 cycle; spl_rx_rd_valid -> rsp_valid 1 cycle. Stats counters only with RD_ARB_STATS_EN.
// Backpressure: no grant while spl_tx_rd_almostfull is high or while an engine has MAX_OUTST reads outstanding.
module rd_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 32,
    parameter int ADDR_W    = 42
) (
    input  logic            clk,
    input  logic            spl_reset,
    rd_req_arbiter_if.slave bus
);
    localparam logic [7:0] MaxOutst = 8'(MAX_OUTST);
    localparam logic [3:0] LastId   = 4'(NUM_REQ - 1);

    logic [7:0]          outst [NUM_REQ];
    logic [3:0]          rrPtr;
    logic [NUM_REQ-1:0]  eligible;
    logic [15:0]         eligPad;
    logic [NUM_REQ-1:0]  grantOneHot;
    logic [NUM_REQ-1:0]  rspHit;
    logic                grantVld;
    logic [3:0]          grantId;
    logic [ADDR_W-1:0]   grantAddr;
    logic [11:0]         grantTag;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] && (outst[i] < MaxOutst) && !bus.spl_tx_rd_almostfull;
        end
        eligPad = 16'(eligible);
    end

    // Scan from rrPtr+1 with wrap; rrPtr < NUM_REQ so a single subtraction does the modulo.
    always_comb begin
        logic [4:0] sum;
        sum      = '0;
        grantVld = 1'b0;
        grantId  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = 5'(rrPtr) + 5'(k);
            if (sum >= 5'(NUM_REQ)) begin
                sum = sum - 5'(NUM_REQ);
            end
            if (!grantVld && eligPad[sum[3:0]]) begin
                grantVld = 1'b1;
                grantId  = sum[3:0];
            end
        end
    end

    always_comb begin
        grantAddr = '0;
        grantTag  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grantOneHot[i] = grantVld && (grantId == 4'(i));
            rspHit[i]      = bus.spl_rx_rd_valid && (bus.spl_rx_rd_mdata[15:12] == 4'(i)) && (outst[i] != 8'd0);
            if (grantOneHot[i]) begin
                grantAddr = bus.req_addr[i*ADDR_W +: ADDR_W];
                grantTag  = bus.req_tag[i*12 +: 12];
            end
        end
        bus.req_ready = grantOneHot;
    end

    always_ff @(posedge clk) begin
        if (spl_reset) begin
            rrPtr               <= LastId;
            bus.afu_tx_rd_valid <= 1'b0;
            bus.afu_tx_rd_addr  <= '0;
            bus.afu_tx_rd_mdata <= '0;
            bus.rsp_valid       <= '0;
            bus.rsp_tag         <= '0;
            bus.rsp_data        <= '0;
            bus.err_sticky      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outst[i] <= '0;
            end
        end else begin
            bus.afu_tx_rd_valid <= grantVld;
            if (grantVld) begin
                rrPtr               <= grantId;
                bus.afu_tx_rd_addr  <= grantAddr;
                bus.afu_tx_rd_mdata <= {grantId, grantTag};
            end
            bus.rsp_valid <= rspHit;
            if (|rspHit) begin
                bus.rsp_tag  <= bus.spl_rx_rd_mdata[11:0];
                bus.rsp_data <= bus.spl_rx_data;
            end
            // Unknown id, or a response with no credit outstanding, is dropped.
            if (bus.spl_rx_rd_valid && !(|rspHit)) begin
                bus.err_sticky <= 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({grantOneHot[i], rspHit[i]})
                    2'b10:   outst[i] <= outst[i] + 8'd1;
                    2'b01:   outst[i] <= outst[i] - 8'd1;
                    default: outst[i] <= outst[i];
                endcase
            end
        end
    end

`ifdef RD_ARB_STATS_EN
    logic [31:0] grantCnt [NUM_REQ];
    logic [31:0] stallCnt;

    always_ff @(posedge clk) begin
        if (spl_reset) begin
            stallCnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                grantCnt[i] <= '0;
            end
        end else begin
            if ((|bus.req_valid) && bus.spl_tx_rd_almostfull) begin
                stallCnt <= stallCnt + 32'd1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grantOneHot[i]) begin
                    grantCnt[i] <= grantCnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.stat_grant_cnt[i*32 +: 32] = grantCnt[i];
        end
        bus.stat_stall_cnt = stallCnt;
    end
`else
    assign bus.stat_grant_cnt = '0;
    assign bus.stat_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_rd_req_arbiter.sv
// Bench for rd_req_arbiter: directed scenarios plus a randomized run against a queue-based reference model.
module tb_rd_req_arbiter;
    localparam int NR = 4;
    localparam int MO = 4;
    localparam int AW = 42;

    logic clk = 1'b0;
    logic spl_reset;
    always #5 clk = ~clk;

    rd_req_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();
    rd_req_arbiter #(.NUM_REQ(NR), .MAX_OUTST(MO), .ADDR_W(AW)) dut (.clk(clk), .spl_reset(spl_reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [15:0] inflight [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid            = '0;
        bus.req_addr             = '0;
        bus.req_tag              = '0;
        bus.spl_tx_rd_almostfull = 1'b0;
        bus.spl_rx_rd_valid      = 1'b0;
        bus.spl_rx_rd_mdata      = '0;
        bus.spl_rx_data          = '0;
    endtask

    task automatic do_reset();
        spl_reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        spl_reset = 1'b0;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic int count_for(input int id);
        int n = 0;
        foreach (inflight[k]) if (int'(inflight[k][15:12]) == id) n++;
        return n;
    endfunction

    task automatic test_reset();
        do_reset();
        total++; if (bus.afu_tx_rd_valid !== 1'b0) begin bad++; $display("FAIL rst_txvld: got %0h want 0", bus.afu_tx_rd_valid); end
        total++; if (bus.afu_tx_rd_addr !== '0) begin bad++; $display("FAIL rst_addr: got %0h want 0", bus.afu_tx_rd_addr); end
        total++; if (bus.afu_tx_rd_mdata !== 16'h0) begin bad++; $display("FAIL rst_mdata: got %0h want 0", bus.afu_tx_rd_mdata); end
        total++; if (bus.rsp_valid !== 4'h0) begin bad++; $display("FAIL rst_rspvld: got %0h want 0", bus.rsp_valid); end
        total++; if (bus.rsp_tag !== 12'h0) begin bad++; $display("FAIL rst_rsptag: got %0h want 0", bus.rsp_tag); end
        total++; if (bus.rsp_data !== '0) begin bad++; $display("FAIL rst_rspdata: got nonzero want 0"); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL rst_err: got %0h want 0", bus.err_sticky); end
        total++; if (bus.stat_grant_cnt !== '0 || bus.stat_stall_cnt !== 32'h0) begin bad++; $display("FAIL rst_stats: got %0h/%0h want 0/0", bus.stat_grant_cnt, bus.stat_stall_cnt); end
        total++; if (bus.req_ready !== 4'h0) begin bad++; $display("FAIL rst_ready_idle: got %0h want 0", bus.req_ready); end
        bus.req_valid = 4'hF;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_prio: got %b want 0001", bus.req_ready); end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req_valid = 4'hF;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(64'h1000 + i);
            bus.req_tag[i*12 +: 12]  = 12'(12'h100 + i);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            total++; if (bus.afu_tx_rd_valid !== 1'b1 || bus.afu_tx_rd_mdata !== {4'(c % NR), 12'(12'h100 + c % NR)})
                begin bad++; $display("FAIL rr_seq[%0d]: got vld=%0h mdata=%0h want vld=1 id=%0d", c, bus.afu_tx_rd_valid, bus.afu_tx_rd_mdata, c % NR); end
            total++; if (bus.afu_tx_rd_addr !== AW'(64'h1000 + c % NR)) begin bad++; $display("FAIL rr_addr[%0d]: got %0h want %0h", c, bus.afu_tx_rd_addr, 64'h1000 + c % NR); end
        end
        idle_inputs();
    endtask

    task automatic test_credit_limit();
        int grants = 0;
        logic [511:0] d;
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_tag[2*12 +: 12] = 12'h123;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.req_ready[2]) grants++;
            tick();
        end
        total++; if (grants != MO) begin bad++; $display("FAIL credit_grants: got %0d want %0d", grants, MO); end
        total++; if (bus.req_ready !== 4'h0) begin bad++; $display("FAIL credit_blocked: got %b want 0000", bus.req_ready); end
        d = rand512();
        bus.spl_rx_rd_valid = 1'b1;
        bus.spl_rx_rd_mdata = 16'h2ABC;
        bus.spl_rx_data     = d;
        #1;
        total++; if (bus.req_ready !== 4'h0) begin bad++; $display("FAIL credit_same_cycle: got %b want 0000", bus.req_ready); end
        tick();
        bus.spl_rx_rd_valid = 1'b0;
        total++; if (bus.rsp_valid !== 4'b0100) begin bad++; $display("FAIL credit_rspvld: got %b want 0100", bus.rsp_valid); end
        total++; if (bus.rsp_tag !== 12'hABC) begin bad++; $display("FAIL credit_rsptag: got %0h want abc", bus.rsp_tag); end
        total++; if (bus.rsp_data !== d) begin bad++; $display("FAIL credit_rspdata: got %0h want %0h", bus.rsp_data[63:0], d[63:0]); end
        grants = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.req_ready[2]) grants++;
            tick();
        end
        total++; if (grants != 1) begin bad++; $display("FAIL credit_regrant: got %0d want 1", grants); end
        idle_inputs();
    endtask

    task automatic test_almostfull();
        do_reset();
        bus.req_valid = 4'b0011;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL af_first: got %b want 0001", bus.req_ready); end
        tick();
        total++; if (bus.afu_tx_rd_valid !== 1'b1 || bus.afu_tx_rd_mdata[15:12] !== 4'd0) begin bad++; $display("FAIL af_pre_tx: got vld=%0h id=%0h want 1/0", bus.afu_tx_rd_valid, bus.afu_tx_rd_mdata[15:12]); end
        bus.spl_tx_rd_almostfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (bus.req_ready !== 4'h0) begin bad++; $display("FAIL af_ready[%0d]: got %b want 0000", c, bus.req_ready); end
            tick();
            total++; if (bus.afu_tx_rd_valid !== 1'b0) begin bad++; $display("FAIL af_txvld[%0d]: got %0h want 0", c, bus.afu_tx_rd_valid); end
        end
        bus.spl_tx_rd_almostfull = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL af_resume: got %b want 0010", bus.req_ready); end
        tick();
        total++; if (bus.afu_tx_rd_valid !== 1'b1 || bus.afu_tx_rd_mdata[15:12] !== 4'd1) begin bad++; $display("FAIL af_resume_tx: got vld=%0h id=%0h want 1/1", bus.afu_tx_rd_valid, bus.afu_tx_rd_mdata[15:12]); end
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        int grants = 0;
        do_reset();
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.req_ready[1]) grants++;
            tick();
        end
        total++; if (grants != 3) begin bad++; $display("FAIL same_setup: got %0d want 3", grants); end
        bus.spl_rx_rd_valid = 1'b1;
        bus.spl_rx_rd_mdata = 16'h1005;
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL same_grant: got %b want 0010", bus.req_ready); end
        tick();
        bus.spl_rx_rd_valid = 1'b0;
        total++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_tag !== 12'h005) begin bad++; $display("FAIL same_rsp: got vld=%b tag=%0h want 0010/5", bus.rsp_valid, bus.rsp_tag); end
        total++; if (bus.afu_tx_rd_valid !== 1'b1) begin bad++; $display("FAIL same_tx: got %0h want 1", bus.afu_tx_rd_valid); end
        grants = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.req_ready[1]) grants++;
            tick();
        end
        total++; if (grants != 1) begin bad++; $display("FAIL same_outst: got %0d more grants want 1", grants); end
        idle_inputs();
    endtask

    task automatic test_errors();
        do_reset();
        bus.spl_rx_rd_valid = 1'b1;
        bus.spl_rx_rd_mdata = 16'h7000;
        tick();
        bus.spl_rx_rd_valid = 1'b0;
        total++; if (bus.rsp_valid !== 4'h0 || bus.err_sticky !== 1'b1) begin bad++; $display("FAIL err_badid: got vld=%b err=%0h want 0000/1", bus.rsp_valid, bus.err_sticky); end
        for (int c = 0; c < 3; c++) tick();
        total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL err_hold: got %0h want 1", bus.err_sticky); end
        do_reset();
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL err_clear: got %0h want 0", bus.err_sticky); end
        bus.spl_rx_rd_valid = 1'b1;
        bus.spl_rx_rd_mdata = 16'h0000;
        tick();
        bus.spl_rx_rd_valid = 1'b0;
        total++; if (bus.rsp_valid !== 4'h0 || bus.err_sticky !== 1'b1) begin bad++; $display("FAIL err_nocredit: got vld=%b err=%0h want 0000/1", bus.rsp_valid, bus.err_sticky); end
        do_reset();
    endtask

    task automatic test_stats();
        int grants = 0;
        int outs   = 0;
        logic [31:0] expG;
        logic [31:0] expS;
`ifdef RD_ARB_STATS_EN
        expG = 32'd10;
        expS = 32'd6;
`else
        expG = 32'd0;
        expS = 32'd0;
`endif
        do_reset();
        bus.req_valid = 4'b1000;
        for (int c = 0; c < 40 && grants < 10; c++) begin
            bus.spl_rx_rd_valid = (outs > 0);
            bus.spl_rx_rd_mdata = 16'h3000;
            if (outs > 0) outs--;
            #1;
            if (bus.req_ready[3]) begin grants++; outs++; end
            tick();
            if (grants == 10) bus.req_valid = '0;
        end
        total++; if (grants != 10) begin bad++; $display("FAIL stats_grants_seen: got %0d want 10", grants); end
        bus.spl_rx_rd_valid = 1'b0;
        bus.req_valid = 4'b1000;
        bus.spl_tx_rd_almostfull = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        idle_inputs();
        tick();
        total++; if (bus.stat_grant_cnt[3*32 +: 32] !== expG) begin bad++; $display("FAIL stats_grant3: got %0d want %0d", bus.stat_grant_cnt[3*32 +: 32], expG); end
        total++; if (bus.stat_grant_cnt[3*32-1:0] !== '0) begin bad++; $display("FAIL stats_grant_other: got %0h want 0", bus.stat_grant_cnt[3*32-1:0]); end
        total++; if (bus.stat_stall_cnt !== expS) begin bad++; $display("FAIL stats_stall: got %0d want %0d", bus.stat_stall_cnt, expS); end
    endtask

    task automatic test_random();
        logic              pend  [NR];
        logic [AW-1:0]     pAddr [NR];
        logic [11:0]       pTag  [NR];
        logic              expTxVld  = 1'b0;
        logic [AW-1:0]     expAddr   = '0;
        logic [15:0]       expMdata  = '0;
        logic [NR-1:0]     expRspVld = '0;
        logic [11:0]       expRspTag = '0;
        logic [511:0]      expRspDat = '0;
        logic [NR-1:0]     expRdy;
        logic [15:0]       word;
        logic [511:0]      d;
        int last = NR - 1;
        int g;
        int id;
        int k;
        logic af;
        logic rxv;
        do_reset();
        inflight.delete();
        for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; pAddr[i] = '0; pTag[i] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            total++; if (bus.afu_tx_rd_valid !== expTxVld || bus.afu_tx_rd_addr !== expAddr || bus.afu_tx_rd_mdata !== expMdata)
                begin bad++; $display("FAIL rnd_tx[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", cyc, bus.afu_tx_rd_valid, bus.afu_tx_rd_addr, bus.afu_tx_rd_mdata, expTxVld, expAddr, expMdata); end
            total++; if (bus.rsp_valid !== expRspVld || bus.rsp_tag !== expRspTag || bus.rsp_data !== expRspDat)
                begin bad++; $display("FAIL rnd_rsp[%0d]: got %b/%0h want %b/%0h", cyc, bus.rsp_valid, bus.rsp_tag, expRspVld, expRspTag); end
            total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL rnd_err[%0d]: got %0h want 0", cyc, bus.err_sticky); end

            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pAddr[i] = AW'({$urandom(), $urandom()});
                    pTag[i]  = 12'($urandom());
                end
                bus.req_valid[i]         = pend[i];
                bus.req_addr[i*AW +: AW] = pAddr[i];
                bus.req_tag[i*12 +: 12]  = pTag[i];
            end
            af = ($urandom_range(0, 4) == 0);
            bus.spl_tx_rd_almostfull = af;

            g = -1;
            for (int j = 1; j <= NR; j++) begin
                id = (last + j) % NR;
                if (g < 0 && pend[id] && count_for(id) < MO && !af) g = id;
            end

            rxv  = 1'b0;
            word = 16'($urandom());
            d    = rand512();
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                k    = $urandom_range(0, inflight.size() - 1);
                word = inflight[k];
                inflight.delete(k);
                rxv  = 1'b1;
            end
            bus.spl_rx_rd_valid = rxv;
            bus.spl_rx_rd_mdata = word;
            bus.spl_rx_data     = d;

            #1;
            expRdy = '0;
            if (g >= 0) expRdy[g] = 1'b1;
            total++; if (bus.req_ready !== expRdy) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, bus.req_ready, expRdy); end

            expTxVld = (g >= 0);
            if (g >= 0) begin
                expAddr  = pAddr[g];
                expMdata = {4'(g), pTag[g]};
                inflight.push_back(expMdata);
                pend[g]  = 1'b0;
                last     = g;
            end
            expRspVld = '0;
            if (rxv) begin
                expRspVld[word[15:12]] = 1'b1;
                expRspTag = word[11:0];
                expRspDat = d;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        spl_reset = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_almostfull();
        test_same_cycle();
        test_errors();
        test_stats();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rd_req_arbiter.md
# rd_req_arbiter

Round-robin arbiter that shares the single CCI-P channel-0 read-request port of `afu_top` among `NUM_REQ` pipeline engines and routes read responses back to the engine that issued them. It sits between the engines and the `afu_tx_rd_*` / `spl_rx_rd_*` signals, upstream of the MPF shim, in the 200 MHz AFU clock domain. It enforces `spl_tx_rd_almostfull` back-pressure and a per-engine outstanding-read credit limit. The requester ID is encoded in the request mdata so that responses can be steered back.

## Interface
Parameters:
- `NUM_REQ`, default 4 — number of requesters; legal range 2..16.
- `MAX_OUTST`, default 32 — maximum outstanding reads per requester; legal range 1..255.
- `ADDR_W`, default 42 — cache-line address width.

Ports:
- `clk` in 1 — AFU clock; all logic is on the rising edge.
- `spl_reset` in 1 — synchronous, active-high reset.
- `req_valid` in NUM_REQ — per-requester read request.
- `req_addr` in NUM_REQ*ADDR_W — flattened line addresses; requester i occupies slice i.
- `req_tag` in NUM_REQ*12 — flattened per-requester tags.
- `req_ready` out NUM_REQ — one-hot grant; combinational.
- `spl_tx_rd_almostfull` in 1 — channel-0 back-pressure.
- `afu_tx_rd_valid` out 1 — registered read-request strobe.
- `afu_tx_rd_addr` out ADDR_W — registered request address.
- `afu_tx_rd_mdata` out 16 — registered; `{id[3:0], tag[11:0]}`. The wrapper packs `addr` and `mdata` into the c0 request header.
- `spl_rx_rd_valid` in 1 — read response strobe.
- `spl_rx_rd_mdata` in 16 — mdata of the response.
- `spl_rx_data` in 512 — response cache line.
- `rsp_valid` out NUM_REQ — registered, one-hot response strobe.
- `rsp_tag` out 12 — registered tag, shared by all requesters.
- `rsp_data` out 512 — registered data, shared by all requesters.
- `err_sticky` out 1 — set on an illegal response; cleared only by reset.
- `stat_grant_cnt` out NUM_REQ*32 — per-requester grant counters; see Configuration.
- `stat_stall_cnt` out 32 — stall-cycle counter; see Configuration.

## Operation
- State per requester: credit counter `outst[i]`, 8 bits, range 0..MAX_OUTST.
- Global state: round-robin pointer `rr_ptr`, the last-granted ID.
- Eligibility: requester i is eligible when `req_valid[i] && outst[i] < MAX_OUTST && !spl_tx_rd_almostfull`.
- Grant: the first eligible requester scanning from `rr_ptr+1` upward, modulo NUM_REQ. At most one grant per cycle. `req_ready[i]` is high only for the granted requester.
- On a grant:
  - `rr_ptr` takes the granted ID.
  - `outst[i]` increments.
  - The address and `{i, tag}` are registered onto `afu_tx_rd_*`.
- When no grant occurs, `afu_tx_rd_valid` is 0 on the next cycle. Address and mdata hold their previous values.
- Response handling, when `spl_rx_rd_valid` is high: `id = spl_rx_rd_mdata[15:12]`.
  - If `id < NUM_REQ` and `outst[id] > 0`: decrement `outst[id]`, register `rsp_valid[id]`=1, `rsp_tag = mdata[11:0]`, `rsp_data`.
  - Otherwise: drop the response (no `rsp_valid`) and set `err_sticky`. Covers `id >= NUM_REQ` and a response arriving with `outst[id]==0`.
- Grant and response to the same requester in the same cycle: `outst` is unchanged (+1 and −1 cancel).
- Requesters must hold `req_valid`, `req_addr` and `req_tag` stable until `req_ready` is seen.
- Reset values:
  - `afu_tx_rd_valid`, `rsp_valid`, `err_sticky`: 0.
  - `afu_tx_rd_addr`, `afu_tx_rd_mdata`, `rsp_tag`, `rsp_data`: 0.
  - All `outst`: 0. `rr_ptr`: NUM_REQ−1, so requester 0 has first priority.
  - Statistics counters: 0.
- Reset mid-operation: all in-flight credits are discarded. Responses arriving after reset find `outst==0` and set `err_sticky`. The system resets the full AFU, so this does not occur in normal use.

## Timing
- Request latency: grant at cycle t drives `afu_tx_rd_valid`=1 at t+1. Back-to-back grants allow 1 request per cycle.
- `spl_tx_rd_almostfull` sampled high at cycle t blocks every grant in cycle t; there is no registered lag. Its 8-entry slack absorbs the one request already in the output register.
- Response latency: `spl_rx_rd_valid` at t drives `rsp_valid` at t+1. The credit is available to the arbiter in t+1.
- Fairness: with all NUM_REQ requesters continuously eligible, each is granted exactly once per NUM_REQ cycles.

## Configuration
- `RD_ARB_STATS_EN` defined:
  - `stat_grant_cnt[i]` increments on every grant to requester i.
  - `stat_stall_cnt` increments each cycle in which any `req_valid` is high and `spl_tx_rd_almostfull` is high.
  - All counters are 32-bit and wrap modulo 2^32.
- Undefined: the statistics ports remain present and are constant 0. The counter logic is not synthesized.

## Test plan
- NUM_REQ=4, all `req_valid` held high for 8 cycles, almostfull=0 → `afu_tx_rd_mdata[15:12]` sequence is 0,1,2,3,0,1,2,3, starting one cycle after the first grant.
- Only requester 2 is valid, MAX_OUTST=4, no responses → exactly 4 grants, then `req_ready[2]` stays 0. One response with mdata=0x2ABC → `rsp_valid`=4'b0100 and `rsp_tag`=0xABC on the next cycle, followed by exactly 1 more grant.
- Almostfull high for 5 cycles while requesters 0 and 1 are valid → `afu_tx_rd_valid`=0 for those 5 cycles plus 1. The first grant after deassertion goes to the requester after `rr_ptr`.
- Requester 1 holds `outst=3`; a grant to requester 1 and a response with mdata=0x1005 occur in the same cycle → `outst` stays 3 and `rsp_valid[1]`=1 one cycle later.
- Response with mdata=0x7000 at NUM_REQ=4, and separately a response to a requester with `outst=0` → no `rsp_valid`, `err_sticky`=1 and held until `spl_reset`.
- With `RD_ARB_STATS_EN`: 10 grants to requester 3 and 6 stalled cycles → `stat_grant_cnt[3]`=10 and `stat_stall_cnt`=6. Without the macro, both read 0.
